// File: rtl/prga_fifo_rr_arbiter.sv
// Round-robin arbiter that merges NUM_SRCS lookahead FIFOs into a single
// registered lookahead output. A granted source may keep the output for up
// to BURST consecutive words. Every output word is tagged with the index of
// the source it came from.
// NUM_SRCS must be 2..16 and BURST must be >= 1.
module prga_fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRCS   = 4,
  parameter int BURST      = 4,
  localparam int SRC_W     = $clog2(NUM_SRCS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRCS-1:0]            src_empty,
  output logic [NUM_SRCS-1:0]            src_rd,
  input  logic [NUM_SRCS*DATA_WIDTH-1:0] src_dout,
  output logic                           empty,
  input  logic                           rd,
  output logic [DATA_WIDTH-1:0]          dout,
  output logic [SRC_W-1:0]               dout_src
);

  localparam int   CNT_W       = $clog2(BURST + 1);
  localparam logic MULTI_BURST = (BURST > 1) ? 1'b1 : 1'b0;

  logic [SRC_W-1:0]      cur_q, cur_d;
  logic                  locked_q, locked_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [SRC_W-1:0]      dout_src_q, dout_src_d;

  logic [SRC_W-1:0]      sel;
  logic                  any_src;
  logic                  load;
  logic                  pop;

  // Index arithmetic modulo NUM_SRCS. This also works when NUM_SRCS is not
  // a power of two.
  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NUM_SRCS) begin
      s = s - NUM_SRCS;
    end else begin
      s = s;
    end
    return SRC_W'(s);
  endfunction

  // Choose a source. A live burst source keeps the grant. Otherwise scan
  // forward from cur+1 and check cur itself last.
  always_comb begin
    logic             found;
    logic [SRC_W-1:0] idx;
    sel   = cur_q;
    found = 1'b0;
    idx   = '0;
    if (locked_q && !src_empty[cur_q]) begin
      sel = cur_q;
    end else begin
      for (int k = 1; k <= NUM_SRCS; k++) begin
        idx = wrap_idx(cur_q, k);
        if (!found && !src_empty[idx]) begin
          sel   = idx;
          found = 1'b1;
        end else begin
          found = found;
        end
      end
    end
  end

  assign any_src = |(~src_empty);
  assign load    = empty_q | rd;
  assign pop     = load & any_src;

  // Drive a single pop strobe toward the selected source. The strobe is
  // held low during reset so the source FIFOs are not disturbed.
  always_comb begin
    src_rd = '0;
    if (pop && rst) begin
      src_rd[sel] = 1'b1;
    end else begin
      src_rd = '0;
    end
  end

  // Next state: load the output register on a pop and track the burst.
  // A read with no refill drains the output register.
  always_comb begin
    cur_d      = cur_q;
    locked_d   = locked_q;
    cnt_d      = cnt_q;
    empty_d    = empty_q;
    dout_d     = dout_q;
    dout_src_d = dout_src_q;
    if (pop) begin
      dout_d     = src_dout[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
      dout_src_d = sel;
      empty_d    = 1'b0;
      if (locked_q && (sel == cur_q)) begin
        cnt_d    = cnt_q + CNT_W'(1);
        locked_d = ((cnt_q + CNT_W'(1)) < CNT_W'(BURST));
      end else begin
        cur_d    = sel;
        cnt_d    = CNT_W'(1);
        locked_d = MULTI_BURST;
      end
    end else if (rd && !empty_q) begin
      empty_d = 1'b1;
    end else begin
      empty_d = empty_q;
    end
  end

  // State and output registers. Reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q      <= SRC_W'(NUM_SRCS - 1);
      locked_q   <= 1'b0;
      cnt_q      <= '0;
      empty_q    <= 1'b1;
      dout_q     <= '0;
      dout_src_q <= '0;
    end else begin
      cur_q      <= cur_d;
      locked_q   <= locked_d;
      cnt_q      <= cnt_d;
      empty_q    <= empty_d;
      dout_q     <= dout_d;
      dout_src_q <= dout_src_d;
    end
  end

  assign empty    = empty_q;
  assign dout     = dout_q;
  assign dout_src = dout_src_q;

endmodule
